// File: rtl/l2_miss_arbiter.sv
// l2_miss_arbiter: shares the single L2 request port between L1_D
// (read / write-through misses) and L1_I (read misses). One transaction is in
// flight at a time and the winner is picked round-robin. The request is
// forwarded with a valid/ready handshake, then the arbiter waits for the L2
// response and returns the line (or a zero write ack) to the owner.
// Optional feature: define ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles and flag the owner's response with resp_err.
module l2_miss_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int LINE_W         = 128,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   input  logic [2:0]        d_req_size,
   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              d_resp_valid,
   output logic [LINE_W-1:0] d_resp_data,
   output logic              d_resp_err,
   output logic              i_resp_valid,
   output logic [LINE_W-1:0] i_resp_data,
   output logic              i_resp_err,
   output logic              l2_req_valid,
   input  logic              l2_req_ready,
   output logic              l2_req_we,
   output logic [ADDR_W-1:0] l2_req_addr,
   output logic [DATA_W-1:0] l2_req_wdata,
   output logic [2:0]        l2_req_size,
   input  logic              l2_resp_valid,
   input  logic [LINE_W-1:0] l2_resp_data,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t            state, state_nxt;
   logic              owner_i_q;   // 1: in-flight transaction belongs to L1_I
   logic              last_i_q;    // 1: last completed grant went to L1_I
   logic              grant_d, grant_i, accept;
   logic              resp_take, timeout;
   logic [LINE_W-1:0] line_in;
   logic [LINE_W-1:0] d_line_q, i_line_q;

   assign d_req_ready = grant_d;
   assign i_req_ready = grant_i;
   assign accept      = grant_d | grant_i;
   assign resp_take   = (state == S_WAIT) && (l2_resp_valid || timeout);
   // Writes and timeouts return an all-zero line.
   assign line_in     = (l2_req_we || !l2_resp_valid) ? '0 : l2_resp_data;
   assign d_resp_data = d_line_q;
   assign i_resp_data = i_line_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state, round-robin grant and handshake outputs
   always_comb begin
      state_nxt    = state;
      grant_d      = 1'b0;
      grant_i      = 1'b0;
      l2_req_valid = 1'b0;
      d_resp_valid = 1'b0;
      i_resp_valid = 1'b0;
      busy         = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (d_req_valid && i_req_valid) begin
               grant_d = last_i_q;
               grant_i = !last_i_q;
            end else begin
               grant_d = d_req_valid;
               grant_i = i_req_valid;
            end
            if (grant_d || grant_i) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            l2_req_valid = 1'b1;
            if (l2_req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (resp_take) state_nxt = S_RESP;
         end
         S_RESP: begin
            d_resp_valid = !owner_i_q;
            i_resp_valid = owner_i_q;
            state_nxt    = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Latched request payload, per-requester response lines and fairness pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_i_q    <= 1'b0;
         last_i_q     <= 1'b1;
         l2_req_we    <= 1'b0;
         l2_req_addr  <= '0;
         l2_req_wdata <= '0;
         l2_req_size  <= 3'd0;
         d_line_q     <= '0;
         i_line_q     <= '0;
      end else begin
         if (accept) begin
            owner_i_q    <= grant_i;
            l2_req_we    <= grant_d & d_req_we;
            l2_req_addr  <= grant_d ? d_req_addr : i_req_addr;
            l2_req_wdata <= grant_d ? d_req_wdata : '0;
            l2_req_size  <= grant_d ? d_req_size : 3'd0;
         end
         if (resp_take) begin
            if (owner_i_q) i_line_q <= line_in;
            else           d_line_q <= line_in;
         end
         if (state == S_RESP) last_i_q <= owner_i_q;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wait_cnt_q;
   logic        err_q;

   // WAIT-cycle counter, held at zero outside WAIT so every entry starts fresh
   always_ff @(posedge clk) begin
      if (rst || state != S_WAIT) wait_cnt_q <= '0;
      else                        wait_cnt_q <= wait_cnt_q + 16'd1;
   end

   assign timeout = (state == S_WAIT) && !l2_resp_valid && (wait_cnt_q == WAIT_LAST);

   // Error flag that accompanies the following response pulse
   always_ff @(posedge clk) begin
      if (rst)            err_q <= 1'b0;
      else if (resp_take) err_q <= timeout;
   end

   assign d_resp_err = d_resp_valid & err_q;
   assign i_resp_err = i_resp_valid & err_q;
`else
   assign timeout    = 1'b0;
   assign d_resp_err = 1'b0;
   assign i_resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_l2_miss_arbiter.sv
// Self-checking bench for l2_miss_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level model.
module tb_l2_miss_arbiter;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         d_req_valid, d_req_ready, d_req_we;
   logic [63:0]  d_req_addr, d_req_wdata;
   logic [2:0]   d_req_size;
   logic         i_req_valid, i_req_ready;
   logic [63:0]  i_req_addr;
   logic         d_resp_valid, d_resp_err, i_resp_valid, i_resp_err;
   logic [127:0] d_resp_data, i_resp_data;
   logic         l2_req_valid, l2_req_ready, l2_req_we;
   logic [63:0]  l2_req_addr, l2_req_wdata;
   logic [2:0]   l2_req_size;
   logic         l2_resp_valid;
   logic [127:0] l2_resp_data;
   logic         busy;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic         pend_d, pend_i, pd_we, last_was_i;
   logic [63:0]  pd_addr, pd_wdata, pi_addr;
   logic [2:0]   pd_size;
   logic [127:0] hold_d, hold_i;

   l2_miss_arbiter #(.ADDR_W(64), .DATA_W(64), .LINE_W(128), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
      .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
      .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_we(l2_req_we),
      .l2_req_addr(l2_req_addr), .l2_req_wdata(l2_req_wdata), .l2_req_size(l2_req_size),
      .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_reset();
      pend_d = 1'b0; pend_i = 1'b0; last_was_i = 1'b1;
      hold_d = '0;   hold_i = '0;
      d_req_valid = 1'b0; i_req_valid = 1'b0;
      l2_req_ready = 1'b0; l2_resp_valid = 1'b0;
   endtask

   task automatic raise_d(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [2:0] sz);
      pend_d = 1'b1; pd_we = we; pd_addr = addr; pd_wdata = wd; pd_size = sz;
   endtask

   task automatic raise_i(input logic [63:0] addr);
      pend_i = 1'b1; pi_addr = addr;
   endtask

   task automatic drive_reqs();
      d_req_valid = pend_d; d_req_we = pd_we; d_req_addr = pd_addr;
      d_req_wdata = pd_wdata; d_req_size = pd_size;
      i_req_valid = pend_i; i_req_addr = pi_addr;
   endtask

   task automatic check_reset_outputs();
      chk("rst d_req_ready", 128'(d_req_ready), 128'(0));
      chk("rst i_req_ready", 128'(i_req_ready), 128'(0));
      chk("rst d_resp_valid", 128'(d_resp_valid), 128'(0));
      chk("rst i_resp_valid", 128'(i_resp_valid), 128'(0));
      chk("rst d_resp_data", d_resp_data, 128'(0));
      chk("rst i_resp_data", i_resp_data, 128'(0));
      chk("rst resp_err", 128'({d_resp_err, i_resp_err}), 128'(0));
      chk("rst l2_req_valid", 128'(l2_req_valid), 128'(0));
      chk("rst l2_payload", {l2_req_we, l2_req_size, l2_req_addr[59:0], l2_req_wdata},
          128'(0));
      chk("rst busy", 128'(busy), 128'(0));
   endtask

   // One complete transaction; winner and results come from the model state.
   task automatic run_txn(input int rdly, input int wdly, input logic [127:0] rdata);
      logic         win_i, we;
      logic [63:0]  addr, wd;
      logic [2:0]   sz;
      logic [127:0] line;
      win_i = (pend_d && pend_i) ? !last_was_i : pend_i;
      we    = win_i ? 1'b0 : pd_we;
      addr  = win_i ? pi_addr : pd_addr;
      wd    = win_i ? 64'd0 : pd_wdata;
      sz    = win_i ? 3'd0 : pd_size;
      drive_reqs();
      #1;
      chk("d_req_ready grant", 128'(d_req_ready), 128'(!win_i));
      chk("i_req_ready grant", 128'(i_req_ready), 128'(win_i));
      chk("idle busy", 128'(busy), 128'(0));
      tick();
      if (win_i) pend_i = 1'b0; else pend_d = 1'b0;
      d_req_valid = pend_d; i_req_valid = pend_i;
      for (int k = 0; k <= rdly; k++) begin
         l2_req_ready  = (k == rdly);
         l2_resp_valid = 1'($urandom_range(0, 1));
         l2_resp_data  = rnd128();
         #1;
         chk("issue l2_req_valid", 128'(l2_req_valid), 128'(1));
         chk("issue l2_req_addr", 128'(l2_req_addr), 128'(addr));
         chk("issue l2_req_we", 128'(l2_req_we), 128'(we));
         chk("issue l2_req_wdata", 128'(l2_req_wdata), 128'(wd));
         chk("issue l2_req_size", 128'(l2_req_size), 128'(sz));
         chk("issue no ready", 128'({d_req_ready, i_req_ready}), 128'(0));
         tick();
      end
      l2_req_ready = 1'b0;
      for (int k = 0; k <= wdly; k++) begin
         l2_resp_valid = (k == wdly);
         l2_resp_data  = (k == wdly) ? rdata : rnd128();
         #1;
         chk("wait l2_req_valid", 128'(l2_req_valid), 128'(0));
         chk("wait no resp", 128'({d_resp_valid, i_resp_valid}), 128'(0));
         chk("wait busy", 128'(busy), 128'(1));
         tick();
      end
      line = we ? 128'd0 : rdata;
      if (win_i) hold_i = line; else hold_d = line;
      l2_resp_valid = 1'($urandom_range(0, 1));
      l2_resp_data  = rnd128();
      #1;
      chk("resp d_resp_valid", 128'(d_resp_valid), 128'(!win_i));
      chk("resp i_resp_valid", 128'(i_resp_valid), 128'(win_i));
      chk("resp d_resp_data", d_resp_data, hold_d);
      chk("resp i_resp_data", i_resp_data, hold_i);
      chk("resp err", 128'({d_resp_err, i_resp_err}), 128'(0));
      last_was_i = win_i;
      tick();
      l2_resp_valid = 1'b0;
      #1;
      chk("post no resp", 128'({d_resp_valid, i_resp_valid}), 128'(0));
      chk("post d_resp_data hold", d_resp_data, hold_d);
      chk("post i_resp_data hold", i_resp_data, hold_i);
      chk("post busy", 128'(busy), 128'(0));
   endtask

   initial begin
      rst = 1'b1;
      d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_size = '0;
      i_req_addr = '0; l2_resp_data = '0;
      pd_we = 1'b0; pd_addr = '0; pd_wdata = '0; pd_size = '0; pi_addr = '0;
      model_reset();
      @(negedge clk);
      tick();
      rst = 1'b0;
      #1;
      check_reset_outputs();

      // basic D read, forwarded address visible the cycle after acceptance
      raise_d(1'b0, 64'h1040, 64'd0, 3'd0);
      run_txn(0, 0, rnd128());

      // round-robin alternation with both requesters pending
      rst = 1'b1; tick(); rst = 1'b0; model_reset();
      raise_d(1'b0, 64'h3000, 64'd0, 3'd0);
      raise_i(64'h4000);
      run_txn(0, 0, rnd128());           // D first after reset
      raise_d(1'b0, 64'h3040, 64'd0, 3'd0);
      run_txn(1, 1, rnd128());           // then I
      raise_i(64'h4040);
      run_txn(0, 2, rnd128());           // then D again
      run_txn(0, 0, rnd128());           // drain I

      // I read with slow L2 ready
      raise_i(64'h2000);
      run_txn(3, 0, 128'hDEADBEEF);

      // D write-through held stable while L2 not ready; ack returns zero line
      raise_d(1'b1, 64'h5008, 64'h55, 3'd3);
      run_txn(3, 1, rnd128());

      // reset while waiting for L2: transaction dropped, late response ignored
      raise_d(1'b0, 64'h6000, 64'd0, 3'd0);
      drive_reqs();
      tick();
      d_req_valid = 1'b0; l2_req_ready = 1'b1;
      tick();
      l2_req_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; model_reset();
      l2_resp_valid = 1'b1; l2_resp_data = rnd128();
      #1;
      chk("rst-wait busy", 128'(busy), 128'(0));
      tick();
      l2_resp_valid = 1'b0;
      #1;
      chk("rst-wait no resp", 128'({d_resp_valid, i_resp_valid}), 128'(0));
      chk("rst-wait busy after", 128'(busy), 128'(0));
      chk("rst-wait d_resp_data", d_resp_data, 128'(0));

      // L2 never answers
      raise_d(1'b0, 64'h7000, 64'd0, 3'd0);
      drive_reqs();
      tick();
      pend_d = 1'b0; d_req_valid = 1'b0; l2_req_ready = 1'b1;
      tick();
      l2_req_ready = 1'b0;
`ifdef ARB_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
         #1;
         chk("timeout wait no resp", 128'(d_resp_valid), 128'(0));
         tick();
      end
      #1;
      chk("timeout d_resp_valid", 128'(d_resp_valid), 128'(1));
      chk("timeout d_resp_err", 128'(d_resp_err), 128'(1));
      chk("timeout d_resp_data", d_resp_data, 128'(0));
      hold_d = '0;
`else
      for (int k = 0; k < TO + 4; k++) begin
         #1;
         chk("no-timeout busy", 128'(busy), 128'(1));
         chk("no-timeout no resp", 128'({d_resp_valid, d_resp_err}), 128'(0));
         tick();
      end
      l2_resp_valid = 1'b1; l2_resp_data = 128'h1234_5678;
      tick();
      l2_resp_valid = 1'b0;
      #1;
      chk("late resp d_resp_valid", 128'(d_resp_valid), 128'(1));
      chk("late resp d_resp_data", d_resp_data, 128'h1234_5678);
      hold_d = 128'h1234_5678;
`endif
      last_was_i = 1'b0;
      tick();
      #1;
      chk("after stall busy", 128'(busy), 128'(0));

      // randomized traffic; a losing requester stays pending with its payload
      for (int n = 0; n < 40; n++) begin
         if (!pend_d && $urandom_range(0, 1) == 1)
            raise_d(1'($urandom_range(0, 1)), rnd64(), rnd64(), 3'($urandom_range(0, 7)));
         if (!pend_i && $urandom_range(0, 1) == 1)
            raise_i(rnd64());
         if (!pend_d && !pend_i)
            raise_i(rnd64());
         run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rnd128());
      end
      while (pend_d || pend_i)
         run_txn(0, 0, rnd128());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
